conv_sequencer: RTL
===================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 8: input image width and height in pixels (square image).
REQ-002 SHALL have parameter KSIZE, default 3: kernel width and height.
REQ-003 SHALL have parameter N_FILT, default 2: number of filters.
REQ-004 SHALL derive OUT_W = IMG_W-KSIZE+1 (6 at defaults), NPOS = OUT_W*OUT_W (36), NTAP = KSIZE*KSIZE (9).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ena, input, 1 bit: advance enable; low freezes the block.
REQ-008 SHALL have port start, input, 1 bit: request a full-image convolution pass.
REQ-009 SHALL have port pix_addr, output, clog2(IMG_W*IMG_W) bits (6): image buffer read address.
REQ-010 SHALL have port wgt_addr, output, clog2(N_FILT*NTAP) bits (5): weight memory read address.
REQ-011 SHALL have port filt_sel, output, clog2(N_FILT) bits (1): filter whose bias and accumulator are active.
REQ-012 SHALL have port mac_clr, output, 1 bit: clears the MAC accumulator to the bias of filt_sel.
REQ-013 SHALL have port mac_en, output, 1 bit: accumulate pixel*weight for the current addresses.
REQ-014 SHALL have port res_valid, output, 1 bit: the MAC result is ready to be consumed.
REQ-015 SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-016 SHALL have port res_pos, output, clog2(NPOS) bits (6): output position (row*OUT_W+col) of the current result.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.

Function
REQ-019 SHALL implement the FSM states IDLE, CLEAR, MAC, EMIT.
REQ-020 IDLE->CLEAR SHALL occur when start=1 and ena=1; pos, filt and tap counters SHALL be 0 on entry to CLEAR.
REQ-021 CLEAR SHALL last exactly 1 cycle, assert mac_clr=1, and go to MAC with tap=0.
REQ-022 MAC SHALL last exactly NTAP cycles, assert mac_en=1 every cycle, increment tap 0..NTAP-1, then go to EMIT.
REQ-023 In MAC, with r=pos/OUT_W, c=pos%OUT_W, t=tap: pix_addr SHALL = (r+t/KSIZE)*IMG_W + c + t%KSIZE and wgt_addr SHALL = filt*NTAP + t (valid window, no padding).
REQ-024 EMIT SHALL hold res_valid=1, with res_pos=pos and filt_sel=filt stable, until res_valid and res_ready are both high at a clock edge.
REQ-025 On acceptance, the FSM SHALL either increment filt and go to CLEAR, or (if filt=N_FILT-1) set filt=0, increment pos and go to CLEAR, or (if additionally pos=NPOS-1) go to IDLE.
REQ-026 Order SHALL be position-major, filter-minor; the minimum pass length SHALL be NPOS*N_FILT*(NTAP+2) cycles (792 at defaults).
REQ-027 done SHALL be high for exactly the first cycle in IDLE after the final acceptance; start sampled in that same cycle SHALL be accepted.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 With ena=0, state and counters SHALL hold, mac_en and mac_clr SHALL be 0, and res_valid/res_pos SHALL hold; a handshake SHALL NOT complete.
REQ-030 pix_addr and wgt_addr SHALL be 0 outside MAC; filt_sel SHALL equal filt in every state except IDLE, where it SHALL be 0.
REQ-031 In the default configuration, counters SHALL never leave their ranges: tap 0..8, filt 0..1, pos 0..35, with no wrap-around.

Reset
REQ-032 While reset=1 the FSM SHALL enter IDLE and all counters SHALL clear; this SHALL apply regardless of ena.
REQ-033 Reset SHALL take priority over start and ena in the same cycle.
REQ-034 Reset SHALL drive pix_addr, wgt_addr, filt_sel, mac_clr, mac_en, res_valid, res_pos, busy and done to 0.
REQ-035 Reset mid-pass SHALL abort the pass without asserting done.

Verification
REQ-036 Basic pass: pulse start with res_ready=1 and ena=1 -> first mac_clr 1 cycle after start; done exactly 792 cycles after start is sampled; 72 accepted results with pos/filt order (0,0),(0,1)..(35,1).
REQ-037 Address check: pos=0, filt=0, tap=4 -> pix_addr=9, wgt_addr=4. pos=7, filt=1, tap=8 -> pix_addr=27, wgt_addr=17. pos=35, tap=8 -> pix_addr=63.
REQ-038 Backpressure: hold res_ready=0 for 5 cycles at pos=3 -> res_valid, res_pos=3 and filt_sel stay stable, with no mac_en during the stall; the pass lengthens by exactly 5 cycles.
REQ-039 ena stall: drop ena for 4 cycles mid-MAC at tap=5 -> tap holds at 5, mac_en=0 during the stall, and the sequence resumes at tap=5.
REQ-040 Start while busy: pulse start at pos=10 -> no restart occurs and the pass completes normally. Start on the done cycle -> a new pass begins immediately with CLEAR on the next cycle.
REQ-041 Reset mid-pass: assert reset at pos=20 -> next cycle all outputs are 0, done is never asserted, and a later start produces a full 792-cycle pass.

Source files
------------

// File: rtl/conv_sequencer.sv
// Address and control sequencer for a valid-window 2-D convolution engine.
// Walks output positions (major) and filters (minor), driving one MAC pass per pair.
module conv_sequencer #(
    parameter int IMG_W  = 8,
    parameter int KSIZE  = 3,
    parameter int N_FILT = 2,
    localparam int OUT_W  = IMG_W - KSIZE + 1,
    localparam int NPOS   = OUT_W * OUT_W,
    localparam int NTAP   = KSIZE * KSIZE,
    localparam int PIX_AW = (IMG_W * IMG_W > 1) ? $clog2(IMG_W * IMG_W) : 1,
    localparam int WGT_AW = (N_FILT * NTAP > 1) ? $clog2(N_FILT * NTAP) : 1,
    localparam int FILT_W = (N_FILT > 1) ? $clog2(N_FILT) : 1,
    localparam int POS_W  = (NPOS > 1) ? $clog2(NPOS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              start,
    output logic [PIX_AW-1:0] pix_addr,
    output logic [WGT_AW-1:0] wgt_addr,
    output logic [FILT_W-1:0] filt_sel,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [POS_W-1:0]  res_pos,
    output logic              busy,
    output logic              done
);
    localparam int RC_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int K_W  = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, MAC, EMIT} state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    // Output position kept as row/col so window addressing needs no divider.
    logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
    logic [K_W-1:0]    trow_q, trow_d, tcol_q, tcol_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            filt_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            trow_q  <= '0;
            tcol_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            filt_q  <= filt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            trow_q  <= trow_d;
            tcol_q  <= tcol_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every *_d gets a hold default first, so no path can infer a latch.
        state_d = state_q;
        pos_d   = pos_q;
        filt_d  = filt_q;
        row_d   = row_q;
        col_d   = col_q;
        trow_d  = trow_q;
        tcol_d  = tcol_q;
        done_d  = done_q;
        if (ena) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = CLEAR;
                        pos_d   = '0;
                        filt_d  = '0;
                        row_d   = '0;
                        col_d   = '0;
                        trow_d  = '0;
                        tcol_d  = '0;
                    end
                end
                CLEAR: begin
                    state_d = MAC;
                    trow_d  = '0;
                    tcol_d  = '0;
                end
                MAC: begin
                    if (tcol_q == K_W'(KSIZE - 1)) begin
                        tcol_d = '0;
                        if (trow_q == K_W'(KSIZE - 1)) begin
                            trow_d  = '0;
                            state_d = EMIT;
                        end else begin
                            trow_d = trow_q + K_W'(1);
                        end
                    end else begin
                        tcol_d = tcol_q + K_W'(1);
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        state_d = CLEAR;
                        if (filt_q != FILT_W'(N_FILT - 1)) begin
                            filt_d = filt_q + FILT_W'(1);
                        end else begin
                            filt_d = '0;
                            if (pos_q == POS_W'(NPOS - 1)) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                                pos_d   = '0;
                                row_d   = '0;
                                col_d   = '0;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                                if (col_q == RC_W'(OUT_W - 1)) begin
                                    col_d = '0;
                                    row_d = row_q + RC_W'(1);
                                end else begin
                                    col_d = col_q + RC_W'(1);
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        mac_clr   = (state_q == CLEAR) && ena;
        mac_en    = (state_q == MAC) && ena;
        res_valid = (state_q == EMIT);
        res_pos   = pos_q;
        filt_sel  = busy ? filt_q : '0;
        done      = done_q;
        pix_addr  = '0;
        wgt_addr  = '0;
        if (state_q == MAC) begin
            pix_addr = PIX_AW'((int'(row_q) + int'(trow_q)) * IMG_W + int'(col_q) + int'(tcol_q));
            wgt_addr = WGT_AW'(int'(filt_q) * NTAP + int'(trow_q) * KSIZE + int'(tcol_q));
        end
    end
endmodule
